// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bus bundle between the fetch stage, its instruction ROM and
//               the downstream control path.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
  logic        pc_increment;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] current_instruction;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] retired_count;
  logic        fetch_error;

  // Fetch-stage side
  modport master (
    input  pc_increment, pc_load, pc_load_value, mem_rdata,
    output mem_addr, mem_rd, current_instruction, instr_valid, pc,
           retired_count, fetch_error
  );

  // Control path / ROM side
  modport slave (
    output pc_increment, pc_load, pc_load_value, mem_rdata,
    input  mem_addr, mem_rd, current_instruction, instr_valid, pc,
           retired_count, fetch_error
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Program counter and instruction fetch stage. Issues one read
//               per fetch to a synchronous ROM of MEM_LATENCY (1..4) cycles,
//               captures the returned word and flags it valid while READY.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_LATENCY = 1
) (
  input  wire logic           clock,
  input  wire logic           resetn,
  instruction_fetch_if.master fetch_bus
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  // Latency compared against the 3-bit capture counter.
  localparam logic [2:0] LAT_C = 3'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;
  logic        error_q, error_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic        mem_rd_o;
  logic        instr_valid_o;
  logic        request_w;

  assign request_w = fetch_bus.pc_increment | fetch_bus.pc_load;

  // Next-state and Moore outputs; requests outside READY are dropped and flagged.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    retired_d     = retired_q;
    error_d       = error_q;
    lat_cnt_d     = lat_cnt_q;
    mem_rd_o      = 1'b0;
    instr_valid_o = 1'b0;
    case (state_q)
      S_ISSUE: begin
        mem_rd_o  = 1'b1;
        lat_cnt_d = 3'd1;
        state_d   = S_WAIT;
        if (request_w) error_d = 1'b1;
      end
      S_WAIT: begin
        if (request_w) error_d = 1'b1;
        if (lat_cnt_q == LAT_C) begin
          instr_d = fetch_bus.mem_rdata;
          state_d = S_READY;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      S_READY: begin
        instr_valid_o = 1'b1;
        if (fetch_bus.pc_load) begin
          pc_d      = fetch_bus.pc_load_value;
          retired_d = retired_q + 16'd1;
          state_d   = S_ISSUE;
        end else if (fetch_bus.pc_increment) begin
          pc_d      = pc_q + 16'd1;
          retired_d = retired_q + 16'd1;
          state_d   = S_ISSUE;
        end
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  // State and datapath registers; reset restarts the fetch at RESET_PC and
  // discards any read still in flight.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_ISSUE;
      pc_q      <= RESET_PC;
      instr_q   <= 16'h0000;
      retired_q <= 16'h0000;
      error_q   <= 1'b0;
      lat_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      error_q   <= error_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // The ROM address is the PC itself, so it stays constant for the whole fetch.
  assign fetch_bus.mem_addr            = pc_q;
  assign fetch_bus.mem_rd              = mem_rd_o;
  assign fetch_bus.current_instruction = instr_q;
  assign fetch_bus.instr_valid         = instr_valid_o;
  assign fetch_bus.pc                  = pc_q;
  assign fetch_bus.retired_count       = retired_q;
  assign fetch_bus.fetch_error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench. Five fetch stages (latencies 1..4, two
//               reset PCs) each with a pipelined ROM, compared every cycle
//               against a countdown reference model, plus directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int NL = 5;

  function automatic int lane_lat(input int i);
    return (i <= 1) ? 1 : i;
  endfunction

  function automatic logic [15:0] lane_rpc(input int i);
    return (i == 1) ? 16'hFFFE : 16'h0000;
  endfunction

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    logic [31:0] p;
    if (a == 16'h0000) return 16'h1234;
    p = 32'(a) * 32'h0000_9E37;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic [NL-1:0]       incr;
  logic [NL-1:0]       load;
  logic [NL-1:0][15:0] lv;

  logic [NL-1:0]       rd_w, valid_w, err_w;
  logic [NL-1:0][15:0] pc_w, addr_w, instr_w, ret_w;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int          L   = lane_lat(gi);
    localparam logic [15:0] RPC = lane_rpc(gi);

    instruction_fetch_if u_if ();
    logic [15:0] pipe [L];

    // ROM with L register stages from address to read data
    always_ff @(posedge clock) begin
      pipe[0] <= rom_word(u_if.mem_addr);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    assign u_if.mem_rdata     = pipe[L-1];
    assign u_if.pc_increment  = incr[gi];
    assign u_if.pc_load       = load[gi];
    assign u_if.pc_load_value = lv[gi];

    instruction_fetch #(.RESET_PC(RPC), .MEM_LATENCY(L)) u_dut (
      .clock     (clock),
      .resetn    (resetn),
      .fetch_bus (u_if)
    );

    assign rd_w[gi]    = u_if.mem_rd;
    assign valid_w[gi] = u_if.instr_valid;
    assign err_w[gi]   = u_if.fetch_error;
    assign pc_w[gi]    = u_if.pc;
    assign addr_w[gi]  = u_if.mem_addr;
    assign instr_w[gi] = u_if.current_instruction;
    assign ret_w[gi]   = u_if.retired_count;
  end

  // Reference model: m_rem counts edges until the instruction becomes valid.
  logic [15:0] m_pc    [NL];
  logic [15:0] m_instr [NL];
  logic [15:0] m_ret   [NL];
  logic        m_err   [NL];
  int          m_rem   [NL];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int lane, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, lane, $time, act, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NL; i++) begin
      if (!resetn) begin
        m_pc[i]    = lane_rpc(i);
        m_instr[i] = 16'h0000;
        m_ret[i]   = 16'h0000;
        m_err[i]   = 1'b0;
        m_rem[i]   = 1 + lane_lat(i);
      end else if (m_rem[i] > 0) begin
        if (incr[i] || load[i]) m_err[i] = 1'b1;
        m_rem[i]--;
        if (m_rem[i] == 0) m_instr[i] = rom_word(m_pc[i]);
      end else if (load[i] || incr[i]) begin
        m_pc[i]  = load[i] ? lv[i] : m_pc[i] + 16'd1;
        m_ret[i] = m_ret[i] + 16'd1;
        m_rem[i] = 1 + lane_lat(i);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NL; i++) begin
      chk("instr_valid", i, 16'(valid_w[i]), 16'(m_rem[i] == 0));
      chk("mem_rd", i, 16'(rd_w[i]), 16'(m_rem[i] == 1 + lane_lat(i)));
      chk("pc", i, pc_w[i], m_pc[i]);
      chk("mem_addr", i, addr_w[i], m_pc[i]);
      chk("current_instruction", i, instr_w[i], m_instr[i]);
      chk("retired_count", i, ret_w[i], m_ret[i]);
      chk("fetch_error", i, 16'(err_w[i]), 16'(m_err[i]));
    end
  endtask

  // One clock: inputs held across the posedge, outputs compared at the negedge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic clear_inputs();
    incr = '0;
    load = '0;
    lv   = '0;
  endtask

  task automatic wait_valid(input int lane, input int budget);
    int n;
    n = 0;
    while (!valid_w[lane] && n < budget) begin
      tick();
      n++;
    end
    if (!valid_w[lane]) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid lane%0d: got timeout after %0d cycles expected instr_valid=1", lane, budget);
    end
  endtask

  typedef struct {
    int          lane;
    logic        inc;
    logic        ld;
    logic [15:0] val;
    logic [15:0] exp_pc;
    logic [15:0] exp_ret;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs [7];
  int   first_seen [NL];

  initial begin
    // Directed advance table (wrap, jump priority, increment after load)
    vecs[0] = '{1, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'd1, rom_word(16'hFFFF)};
    vecs[1] = '{1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd2, 16'h1234};
    vecs[2] = '{0, 1'b0, 1'b1, 16'h0005, 16'h0005, 16'd1, rom_word(16'h0005)};
    vecs[3] = '{0, 1'b1, 1'b1, 16'h0040, 16'h0040, 16'd2, rom_word(16'h0040)};
    vecs[4] = '{2, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'd1, rom_word(16'h0001)};
    vecs[5] = '{2, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'd2, rom_word(16'hFFFF)};
    vecs[6] = '{2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd3, 16'h1234};

    for (int i = 0; i < NL; i++) begin
      m_pc[i] = lane_rpc(i); m_instr[i] = '0; m_ret[i] = '0; m_err[i] = 1'b0;
      m_rem[i] = 1 + lane_lat(i);
    end
    clear_inputs();
    resetn = 1'b0;

    // Reset and first fetch
    tick();
    tick();
    chk("reset_mem_rd", 0, 16'(rd_w[0]), 16'd1);
    chk("reset_mem_addr", 0, addr_w[0], 16'h0000);
    chk("reset_valid", 0, 16'(valid_w[0]), 16'd0);
    chk("reset_fetch_error", 0, 16'(err_w[0]), 16'd0);
    resetn = 1'b1;
    tick();
    chk("first_fetch_mem_rd_once", 0, 16'(rd_w[0]), 16'd0);
    chk("first_fetch_valid_early", 0, 16'(valid_w[0]), 16'd0);
    tick();
    chk("first_fetch_valid", 0, 16'(valid_w[0]), 16'd1);
    chk("first_fetch_instr", 0, instr_w[0], 16'h1234);
    chk("first_fetch_retired", 0, ret_w[0], 16'd0);

    // Table-driven advances
    for (int v = 0; v < 7; v++) begin
      wait_valid(vecs[v].lane, 20);
      incr[vecs[v].lane] = vecs[v].inc;
      load[vecs[v].lane] = vecs[v].ld;
      lv[vecs[v].lane]   = vecs[v].val;
      tick();
      clear_inputs();
      chk("valid_drop", vecs[v].lane, 16'(valid_w[vecs[v].lane]), 16'd0);
      wait_valid(vecs[v].lane, 20);
      chk("vec_pc", vecs[v].lane, pc_w[vecs[v].lane], vecs[v].exp_pc);
      chk("vec_retired", vecs[v].lane, ret_w[vecs[v].lane], vecs[v].exp_ret);
      chk("vec_instr", vecs[v].lane, instr_w[vecs[v].lane], vecs[v].exp_instr);
    end

    // Illegal advance during WAIT, latency 3
    wait_valid(3, 20);
    incr[3] = 1'b1;
    tick();                       // accepted: pc 0 -> 1, ISSUE
    clear_inputs();
    tick();                       // WAIT
    incr[3] = 1'b1;
    tick();                       // ignored request
    clear_inputs();
    chk("illegal_pc_hold", 3, pc_w[3], 16'h0001);
    chk("illegal_error_set", 3, 16'(err_w[3]), 16'd1);
    tick();
    chk("illegal_not_yet_valid", 3, 16'(valid_w[3]), 16'd0);
    tick();
    chk("illegal_capture_at_4", 3, 16'(valid_w[3]), 16'd1);
    chk("illegal_instr", 3, instr_w[3], rom_word(16'h0001));
    for (int k = 0; k < 4; k++) tick();
    chk("illegal_error_sticky", 3, 16'(err_w[3]), 16'd1);

    // Latency sweep: advance every lane on the same edge
    for (int i = 0; i < NL; i++) wait_valid(i, 20);
    incr = '1;
    tick();
    clear_inputs();
    for (int i = 0; i < NL; i++) first_seen[i] = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int i = 0; i < NL; i++)
        if (valid_w[i] && first_seen[i] < 0) first_seen[i] = c;
    end
    for (int i = 0; i < NL; i++)
      chk("advance_to_valid_cycles", i, 16'(first_seen[i]), 16'(1 + lane_lat(i)));

    // Reset in the middle of a fetch to address 7, latency 4
    wait_valid(4, 20);
    load[4] = 1'b1;
    lv[4]   = 16'h0007;
    tick();
    clear_inputs();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("midreset_mem_rd", 4, 16'(rd_w[4]), 16'd1);
    chk("midreset_mem_addr", 4, addr_w[4], 16'h0000);
    chk("midreset_fetch_error", 4, 16'(err_w[4]), 16'd0);
    wait_valid(4, 20);
    chk("midreset_instr", 4, instr_w[4], 16'h1234);
    chk("midreset_pc", 4, pc_w[4], 16'h0000);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NL; i++) begin
        incr[i] = ($urandom_range(0, 2) == 0);
        load[i] = ($urandom_range(0, 5) == 0);
        lv[i]   = 16'($urandom);
      end
      resetn = ($urandom_range(0, 149) != 0);
      tick();
    end
    clear_inputs();
    resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and instruction-fetch stage directly upstream of the control path. Holds the PC, issues reads to the synchronous instruction ROM, and registers the returned word as `current_instruction`. Advances on the control path's `program_counter_increment` pulse or loads a jump target. Asserts `instr_valid` only while the presented instruction is stable and executable.

## Interface

**Parameters**
- `RESET_PC`, default 16'h0000: PC value after reset.
- `MEM_LATENCY`, default 1: ROM read latency in cycles. Legal range is 1..4.

**Ports**
- `clock` input 1: all state updates on the posedge.
- `resetn` input 1: reset, synchronous, active-low.
- `pc_increment` input 1: advance to PC+1. Sampled only in READY.
- `pc_load` input 1: jump. Sampled only in READY.
- `pc_load_value` input 16: jump target.
- `mem_rdata` input 16: ROM read data.
- `mem_addr` output 16: ROM address. Always equal to `pc`.
- `mem_rd` output 1: ROM read strobe. High for exactly one cycle per fetch.
- `current_instruction` output 16: registered instruction word.
- `instr_valid` output 1: `current_instruction` is valid for execution.
- `pc` output 16: address of the instruction being fetched or held.
- `retired_count` output 16: number of accepted advances (increment or load). Wraps at 16'hFFFF.
- `fetch_error` output 1: sticky. Set when an advance request arrives outside READY.

## Operation

**States**
- ISSUE: `mem_rd`=1, `instr_valid`=0. Next state is WAIT, with `lat_cnt`<=1.
- WAIT: `mem_rd`=0, `instr_valid`=0.
  - If `lat_cnt`==`MEM_LATENCY`: `current_instruction`<=`mem_rdata`, go to READY.
  - Otherwise `lat_cnt`++.
- READY: `instr_valid`=1, `mem_rd`=0.
  - If `pc_load`: `pc`<=`pc_load_value`.
  - Else if `pc_increment`: `pc`<=`pc`+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - On either, `retired_count`++ and go to ISSUE.
  - With neither, stay in READY and hold all outputs.

**Priority and boundary rules**
- `pc_load` wins over `pc_increment` when both are high in the same cycle. This counts as one retirement.
- `pc_increment` or `pc_load` asserted in ISSUE or WAIT:
  - the request is ignored;
  - `pc` and the fetch in progress are unaffected;
  - `fetch_error`<=1 and holds until reset.
- `current_instruction` retains its previous value during ISSUE and WAIT. Consumers must qualify it with `instr_valid`. At top level, the control path's increment is ANDed with `instr_valid`.
- `mem_addr` is stable from ISSUE through the capture edge, so multi-cycle ROMs see a constant address.
- `lat_cnt` is 3 bits and is never compared beyond `MEM_LATENCY`.

**Reset** (resetn=0 at a posedge, from any state, including mid-fetch)
- State goes to ISSUE.
- `pc`=`RESET_PC`, `current_instruction`=16'h0000, `retired_count`=0, `fetch_error`=0, `lat_cnt`=0.
- Outputs during and immediately after reset: `instr_valid`=0, `mem_rd`=1 (ISSUE), `mem_addr`=`RESET_PC`.
- Data returning from an aborted fetch is discarded, because the capture counter restarts.

## Timing

- All registers update on the posedge of `clock`. The control path samples on the negedge, so outputs are stable half a cycle before it uses them.
- Let E0 be the edge that samples the advance (or reset release).
  - ISSUE is active in cycle E0–E1; the ROM samples `mem_addr` at E1.
  - The capture edge is E(1+`MEM_LATENCY`).
  - `instr_valid` rises after that edge.
- Advance-to-valid latency is 1+`MEM_LATENCY` cycles. The default is 2.
- `instr_valid` falls in the cycle directly after an accepted advance, never later.
- Minimum instruction period is 2+`MEM_LATENCY` cycles: one READY cycle plus the fetch.
- `mem_rd` is a Moore output of ISSUE, glitch-free, and is never asserted on two consecutive cycles.

## Test plan

1. **Reset and first fetch.** `MEM_LATENCY`=1, ROM[0]=16'h1234. Hold resetn=0 for 2 cycles, then release. Required: `mem_rd` high for exactly 1 cycle with `mem_addr`=0; `instr_valid`=1 and `current_instruction`=16'h1234 two cycles after release; `retired_count`=0.
2. **Sequential advance and wrap.** `RESET_PC`=16'hFFFE. Pulse `pc_increment` in READY twice. Required: `pc` goes 16'hFFFF then 16'h0000; the correct ROM words are captured; `retired_count`=2.
3. **Jump priority.** In READY with `pc`=5, assert `pc_load`=1 with `pc_load_value`=16'h0040, and `pc_increment`=1, together. Required: `pc`=16'h0040 (not 6); `retired_count` increases by 1.
4. **Illegal advance.** `MEM_LATENCY`=3. Pulse `pc_increment` during WAIT. Required: `pc` unchanged; capture occurs 4 cycles after ISSUE begins; `fetch_error`=1 and stays 1 until reset.
5. **Reset mid-fetch.** Assert resetn=0 for one cycle during WAIT of a fetch to address 7. Required: next state is ISSUE with `mem_addr`=`RESET_PC`; the word from address 7 is never presented with `instr_valid`=1; `fetch_error`=0.
6. **Latency sweep.** For `MEM_LATENCY`=1..4, repeat the advance-to-valid check. Required: `instr_valid` rises exactly 1+`MEM_LATENCY` cycles after the accepting edge.
